// File: rtl/hilo_mac_unit.sv
// hilo_mac_unit
//
// Multi-cycle multiply / multiply-accumulate unit that owns the MIPS HI and LO
// registers. The control unit pulses start with an opcode and stalls while busy.
// Multiplies run on operand magnitudes with a shift-add loop that retires
// BITS_PER_CYCLE multiplier bits per cycle. A single accumulate cycle then
// applies the sign and writes, adds or subtracts the result into {hi, lo}.
//
// Opcodes (op):
//   000 MULT   001 MULTU  010 MADD   011 MADDU
//   100 MSUB   101 MSUBU  110 MTHI   111 MTLO
//
// Ports:
//   clk    - clock; all state changes happen on the rising edge
//   reset  - asynchronous, active-high reset
//   start  - operation request; accepted only while busy is low
//   op     - opcode, listed above
//   a, b   - rs / rt operands; latched when start is accepted
//   busy   - a multiply or accumulate operation is in flight
//   done   - one-cycle pulse; hi/lo were updated on the preceding edge
//   hi, lo - HI and LO registers
//
// Parameters:
//   WIDTH          - operand width; hi and lo are each WIDTH bits
//   BITS_PER_CYCLE - multiplier bits retired per MUL cycle; must divide WIDTH
//
// Build option:
//   MAC_SATURATE_EN - when defined, accumulates saturate instead of wrapping:
//                     MADD/MSUB clamp to the signed 2*WIDTH range, MADDU clamps
//                     to all-ones on carry and MSUBU clamps to zero on borrow.

module hilo_mac_unit #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned Steps = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW  = (Steps > 1) ? $clog2(Steps) : 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = WIDTH + BITS_PER_CYCLE;

  // op[2:1] selects the kind of operation; op[0] selects unsigned / LO.
  localparam logic [1:0] KindMul  = 2'b00;
  localparam logic [1:0] KindAdd  = 2'b01;
  localparam logic [1:0] KindSub  = 2'b10;
  localparam logic [1:0] KindMove = 2'b11;

`ifdef MAC_SATURATE_EN
  localparam logic [PW-1:0] SatMax = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] SatMin = {1'b1, {(PW-1){1'b0}}};
`endif

  if ((BITS_PER_CYCLE == 0) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : gen_cfg_check
    $error("hilo_mac_unit: BITS_PER_CYCLE must be non-zero and divide WIDTH");
  end

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StAcc
  } state_e;

  state_e           state_q;
  logic [1:0]       kind_q;
`ifdef MAC_SATURATE_EN
  logic             uns_q;
`endif
  logic             neg_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] mcand_q;
  // Upper half accumulates partial sums; the lower half starts as the multiplier
  // magnitude and is shifted out as its digits are consumed.
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

  // Operand magnitudes and result sign, evaluated on the start cycle.
  logic             op_signed;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             start_neg;

  always_comb begin
    op_signed = ~op[0];
    // -(-2^(WIDTH-1)) wraps back to 2^(WIDTH-1), which is its exact unsigned magnitude.
    a_mag     = (op_signed && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;
    start_neg = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  // One shift-add step: add mcand * digit to the upper half, then shift the
  // whole product right by BITS_PER_CYCLE.
  logic [BITS_PER_CYCLE-1:0] digit;
  logic [SW-1:0]             step_sum;
  logic [PW-1:0]             step_prod;

  always_comb begin
    digit     = prod_q[BITS_PER_CYCLE-1:0];
    step_sum  = SW'(prod_q[PW-1:WIDTH]) + (SW'(mcand_q) * SW'(digit));
    step_prod = (PW'(step_sum) << (WIDTH - BITS_PER_CYCLE))
              | PW'(prod_q[WIDTH-1:0] >> BITS_PER_CYCLE);
  end

  // Accumulate stage.
  logic [PW-1:0] hilo;
  logic [PW-1:0] prod_signed;
  logic [PW-1:0] acc_sum;
  logic [PW-1:0] acc_diff;
  logic [PW-1:0] acc_result;

  always_comb begin
    hilo        = {hi_q, lo_q};
    prod_signed = neg_q ? (PW'(0) - prod_q) : prod_q;
    acc_sum     = hilo + prod_signed;
    acc_diff    = hilo - prod_signed;
    acc_result  = hilo;
    case (kind_q)
      KindMul:  acc_result = prod_signed;
      KindAdd:  acc_result = acc_sum;
      KindSub:  acc_result = acc_diff;
      KindMove: acc_result = hilo;
      default:  acc_result = hilo;
    endcase
`ifdef MAC_SATURATE_EN
    if (kind_q == KindAdd) begin
      if (uns_q) begin
        // Unsigned carry out: the wrapped sum is smaller than an addend.
        if (acc_sum < hilo) begin
          acc_result = '1;
        end
      end else if ((hilo[PW-1] == prod_signed[PW-1]) && (acc_sum[PW-1] != hilo[PW-1])) begin
        acc_result = hilo[PW-1] ? SatMin : SatMax;
      end
    end else if (kind_q == KindSub) begin
      if (uns_q) begin
        if (hilo < prod_signed) begin
          acc_result = '0;
        end
      end else if ((hilo[PW-1] != prod_signed[PW-1]) && (acc_diff[PW-1] != hilo[PW-1])) begin
        acc_result = hilo[PW-1] ? SatMin : SatMax;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      kind_q  <= KindMul;
`ifdef MAC_SATURATE_EN
      uns_q   <= 1'b0;
`endif
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (op[2:1] == KindMove) begin
              // MTHI / MTLO complete in place without raising busy.
              if (op[0]) begin
                lo_q <= a;
              end else begin
                hi_q <= a;
              end
              done_q <= 1'b1;
            end else begin
              kind_q  <= op[2:1];
`ifdef MAC_SATURATE_EN
              uns_q   <= op[0];
`endif
              neg_q   <= start_neg;
              mcand_q <= a_mag;
              prod_q  <= PW'(b_mag);
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= StMul;
            end
          end
        end
        StMul: begin
          prod_q <= step_prod;
          cnt_q  <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(Steps - 1)) begin
            state_q <= StAcc;
          end
        end
        StAcc: begin
          {hi_q, lo_q} <= acc_result;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mac_unit.sv
module tb_hilo_mac_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         start4;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy4;
  logic         done4;
  logic [W-1:0] hi4;
  logic [W-1:0] lo4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] sb_q[$];
  logic [63:0] model_hilo;
  logic [63:0] committed;
  logic [63:0] popped;

  logic [31:0] corners [5] = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'hFFFF_FFFF};

`ifdef MAC_SATURATE_EN
  localparam logic signed [65:0] RefSMax = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] RefSMin = 66'sh3_8000_0000_0000_0000;
  localparam logic signed [65:0] RefUMax = 66'sh0_FFFF_FFFF_FFFF_FFFF;
`endif

  hilo_mac_unit #(
    .WIDTH          (W),
    .BITS_PER_CYCLE (1)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  hilo_mac_unit #(
    .WIDTH          (W),
    .BITS_PER_CYCLE (4)
  ) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .start (start4),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy4),
    .done  (done4),
    .hi    (hi4),
    .lo    (lo4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: full-precision signed arithmetic, then wrap or clamp to 64 bits.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] acc);
    logic signed [65:0] sx, sy, p, accx, r;
    if (o == 3'b110) return {x, acc[31:0]};
    if (o == 3'b111) return {acc[63:32], x};
    sx   = o[0] ? $signed({34'd0, x}) : $signed({{34{x[31]}}, x});
    sy   = o[0] ? $signed({34'd0, y}) : $signed({{34{y[31]}}, y});
    p    = sx * sy;
    accx = o[0] ? $signed({2'b00, acc}) : $signed({{2{acc[63]}}, acc});
    case (o[2:1])
      2'b00:   r = p;
      2'b01:   r = accx + p;
      default: r = accx - p;
    endcase
`ifdef MAC_SATURATE_EN
    if (o[2:1] != 2'b00) begin
      if (o[0]) begin
        if (r > RefUMax) r = RefUMax;
        else if (r < 0) r = 0;
      end else begin
        if (r > RefSMax) r = RefSMax;
        else if (r < RefSMin) r = RefSMin;
      end
    end
`endif
    return r[63:0];
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    while (busy === 1'b1 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("issue_wait_timeout", 64'(busy), 64'd0);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    model_hilo = ref_op(o, x, y, model_hilo);
    sb_q.push_back(model_hilo);
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the buses: the unit must work from its latched copies.
    op = 3'($urandom);
    a  = $urandom;
    b  = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while ((busy === 1'b1 || sb_q.size() != 0) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 64'(busy) + 64'(sb_q.size()), 64'd0);
  endtask

  task automatic spurious_start();
    op    = 3'($urandom);
    a     = $urandom;
    b     = $urandom;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every done, and checks hi/lo hold while busy.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_done: done=1 with no operation outstanding, hilo=%h", {hi, lo});
        end else begin
          popped = sb_q.pop_front();
          check("scoreboard_result", {hi, lo}, popped);
          committed = popped;
        end
      end
      if (busy === 1'b1) check("hold_while_busy", {hi, lo}, committed);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    int guard;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    reset      = 1'b1;
    start      = 1'b0;
    start4     = 1'b0;
    op         = 3'b000;
    a          = '0;
    b          = '0;
    model_hilo = '0;
    committed  = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_flags", {62'd0, busy, done}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: MULTU all-ones, busy length and done pulse width.
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("t1_busy_cycles", 64'(cyc), 64'd33);
    check("t1_result", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    check("t1_done_rise", 64'(done), 64'd1);
    @(posedge clk); #1;
    check("t1_done_fall", 64'(done), 64'd0);
    drain();

    // 2: signed MULT, including the most-negative squared.
    issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    drain();
    check("t2_mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'b000, 32'h8000_0000, 32'h8000_0000);
    drain();
    check("t2_mult_minsq", {hi, lo}, 64'h4000_0000_0000_0000);

    // 3: moves, then accumulate.
    issue(3'b110, 32'd5, 32'd0);
    check("t3_mthi_busy", 64'(busy), 64'd0);
    check("t3_mthi_done", 64'(done), 64'd1);
    issue(3'b111, 32'd16, 32'd0);
    check("t3_mtlo_busy", 64'(busy), 64'd0);
    issue(3'b010, 32'd2, 32'd3);
    drain();
    check("t3_madd", {hi, lo}, {32'd5, 32'd22});
    issue(3'b101, 32'd4, 32'd4);
    drain();
    check("t3_msubu", {hi, lo}, {32'd5, 32'd6});

    // 4: start while busy is ignored; reissue on the done cycle is accepted.
    issue(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) begin
      @(posedge clk); #1;
    end
    spurious_start();
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t4_done_seen", 64'(done), 64'd1);
    issue(3'b000, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    check("t4_back_to_back_busy", 64'(busy), 64'd1);
    drain();

    // 5: asynchronous reset mid-multiply, then a fresh operation right after.
    issue(3'b000, 32'h0000_0007, 32'hFFFF_FFF0);
    repeat (11) begin
      @(posedge clk); #1;
    end
    #1 reset = 1'b1;
    #1;
    check("t5_reset_hilo", {hi, lo}, 64'd0);
    check("t5_reset_flags", {62'd0, busy, done}, 64'd0);
    #1 reset = 1'b0;
    sb_q.delete();
    model_hilo = '0;
    committed  = '0;
    issue(3'b001, 32'd3, 32'd7);
    drain();
    check("t5_after_reset", {hi, lo}, 64'd21);

    // 6: MADDU carry out of {hi, lo}.
    issue(3'b110, 32'hFFFF_FFFF, 32'd0);
    issue(3'b111, 32'hFFFF_FFFF, 32'd0);
    issue(3'b011, 32'd1, 32'd1);
    drain();
`ifdef MAC_SATURATE_EN
    check("t6_maddu_sat", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    check("t6_maddu_wrap", {hi, lo}, 64'd0);
`endif

    // 6b: four bits per cycle.
    op     = 3'b001;
    a      = 32'hFFFF_FFFF;
    b      = 32'hFFFF_FFFF;
    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (busy4 === 1'b1 && cyc < 100) begin
      cyc++;
      @(posedge clk); #1;
    end
    check("t6_bpc4_busy_cycles", 64'(cyc), 64'd9);
    check("t6_bpc4_result", {hi4, lo4}, 64'hFFFF_FFFE_0000_0001);
    check("t6_bpc4_done", 64'(done4), 64'd1);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      issue(ro, ra, rb);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 5)) begin
          @(posedge clk); #1;
        end
        if (busy === 1'b1) spurious_start();
      end
    end
    drain();
    check("final_hilo", {hi, lo}, model_hilo);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
